// File: rtl/dcp_dump.sv
// dcp_dump: walks a storage range and prints "<PREFIX><hex addr>=<word>" per entry, then CR LF.
// Optional DCP_LINE_CRLF_EN: emit CR LF after every entry instead of only after the last one.
`timescale 1ns/1ps
`default_nettype none

module dcp_dump #(
   parameter int          NREG     = 32,
   parameter int          AW       = 5,
   parameter int          DW       = 32,
   parameter int          ADDR_HEX = 2,
   parameter logic [7:0]  PREFIX   = 8'h52
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [7:0]    sel_mode,
   input  logic [7:0]    cmd_code,
   input  logic [AW-1:0] start_addr,
   input  logic [AW:0]   count,
   output logic          finish,
   output logic          req_tx,
   output logic          type_tx,
   input  logic          ack_tx,
   output logic [AW-1:0] addr,
   input  logic [DW-1:0] dout_rf,
   output logic [DW-1:0] dout
);

   localparam int DIGW = (ADDR_HEX > 1) ? $clog2(ADDR_HEX) : 1;
   localparam int AXW  = 4 * ADDR_HEX;

   typedef enum logic [3:0] {
      S_IDLE, S_PFX, S_ADR, S_EQ, S_FETCH, S_DAT, S_NEXT, S_CR, S_LF, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [AW:0]     rem_q, rem_d;
   logic [DIGW-1:0] dig_q, dig_d;
   logic [DW-1:0]   data_q, data_d;
   logic            req_q, req_d;
   logic            fin_q, fin_d;

   logic            act;
   logic [AXW-1:0]  addr_ext;
   logic [DIGW-1:0] dsel;
   logic [3:0]      nib;
   logic [AW:0]     cnt_clamp;

   function automatic logic [7:0] hex_char(input logic [3:0] d);
      return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
   endfunction

   assign act       = (sel_mode == cmd_code);
   assign addr_ext  = AXW'(addr_q);
   assign dsel      = DIGW'(ADDR_HEX - 1) - dig_q;
   assign nib       = addr_ext[4*dsel +: 4];
   assign cnt_clamp = ((count == '0) || (count > (AW+1)'(NREG))) ? (AW+1)'(NREG) : count;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         dig_q   <= '0;
         data_q  <= '0;
         req_q   <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         dig_q   <= dig_d;
         data_q  <= data_d;
         req_q   <= req_d;
         fin_q   <= fin_d;
      end
   end

   // Print states raise req on entry; after the ack, one low cycle precedes the next
   // character. EQ/DAT use the following FETCH/NEXT cycle as that low cycle.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      dig_d   = dig_q;
      data_d  = data_q;
      req_d   = req_q;
      fin_d   = fin_q;
      if (!act) begin
         state_d = S_IDLE;
         req_d   = 1'b0;
         fin_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               addr_d  = start_addr;
               rem_d   = cnt_clamp;
               dig_d   = '0;
               state_d = S_PFX;
               req_d   = 1'b1;
            end
            S_PFX: begin
               if (req_q) begin
                  req_d = ~ack_tx;
               end else begin
                  state_d = S_ADR;
                  dig_d   = '0;
                  req_d   = 1'b1;
               end
            end
            S_ADR: begin
               if (req_q) begin
                  req_d = ~ack_tx;
               end else begin
                  req_d = 1'b1;
                  if (dig_q == DIGW'(ADDR_HEX - 1)) state_d = S_EQ;
                  else                              dig_d   = dig_q + 1'b1;
               end
            end
            S_EQ: begin
               if (req_q && ack_tx) begin
                  req_d   = 1'b0;
                  state_d = S_FETCH;
               end
            end
            S_FETCH: begin
               data_d  = dout_rf;
               state_d = S_DAT;
               req_d   = 1'b1;
            end
            S_DAT: begin
               if (req_q && ack_tx) begin
                  req_d   = 1'b0;
                  state_d = S_NEXT;
               end
            end
            S_NEXT: begin
               rem_d  = rem_q - (AW+1)'(1);
               addr_d = (addr_q == AW'(NREG - 1)) ? '0 : addr_q + 1'b1;
               req_d  = 1'b1;
               if (rem_q == (AW+1)'(1)) state_d = S_CR;
               else begin
`ifdef DCP_LINE_CRLF_EN
                  state_d = S_CR;
`else
                  state_d = S_PFX;
`endif
               end
            end
            S_CR: begin
               if (req_q) begin
                  req_d = ~ack_tx;
               end else begin
                  state_d = S_LF;
                  req_d   = 1'b1;
               end
            end
            S_LF: begin
               // rem_q is zero only after the final entry's line break
               if (req_q) begin
                  if (ack_tx) begin
                     req_d = 1'b0;
                     if (rem_q == '0) begin
                        state_d = S_DONE;
                        fin_d   = 1'b1;
                     end
                  end
               end else begin
                  state_d = S_PFX;
                  req_d   = 1'b1;
               end
            end
            S_DONE:  fin_d   = 1'b1;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      dout = '0;
      case (state_q)
         S_PFX:   dout = DW'(PREFIX);
         S_ADR:   dout = DW'(hex_char(nib));
         S_EQ:    dout = DW'(8'h3D);
         S_DAT:   dout = data_q;
         S_CR:    dout = DW'(8'h0D);
         S_LF:    dout = DW'(8'h0A);
         default: dout = '0;
      endcase
   end

   assign req_tx  = req_q;
   assign finish  = fin_q;
   assign addr    = addr_q;
   assign type_tx = (state_q == S_DAT);

endmodule

`default_nettype wire

// File: tb/tb_dcp_dump.sv
// tb_dcp_dump: directed, self-checking bench for dcp_dump with a delayed-ack transmitter model.
`timescale 1ns/1ps
`default_nettype none

module tb_dcp_dump;
   localparam int         NREG = 32;
   localparam int         AW   = 5;
   localparam int         DW   = 32;
   localparam logic [7:0] CMD  = 8'hA5;
   localparam logic [7:0] PFXC = 8'h52;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [7:0]    sel_mode = 8'h00;
   logic [7:0]    cmd_code = CMD;
   logic [AW-1:0] start_addr = '0;
   logic [AW:0]   count = '0;
   logic          ack_tx = 1'b0;
   logic [DW-1:0] rf [NREG];
   logic [DW-1:0] dout_rf;
   logic          finish, req_tx, type_tx;
   logic [AW-1:0] addr;
   logic [DW-1:0] dout;

   dcp_dump dut (
      .clk(clk), .rstn(rstn), .sel_mode(sel_mode), .cmd_code(cmd_code),
      .start_addr(start_addr), .count(count), .finish(finish), .req_tx(req_tx),
      .type_tx(type_tx), .ack_tx(ack_tx), .addr(addr), .dout_rf(dout_rf), .dout(dout)
   );

   assign dout_rf = rf[addr];
   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [32:0] got [$];
   logic [32:0] exp_q [$];
   int          ack_dly = 0;
   int          wcnt = 0;
   logic        force_ack = 1'b0;
   logic        prev_req = 1'b0;
   logic        have_prev = 1'b0;
   int          low_run = 0;
   int          gap_bad = 0;
   int          stab_bad = 0;
   int          words = 0;
   logic [32:0] hold_val = '0;

   // Transmitter model: acks after ack_dly held cycles, logs each acked item,
   // and tracks payload stability and low-cycle gaps between requests.
   always @(negedge clk) begin
      if (req_tx) begin
         if (!prev_req) begin
            hold_val = {type_tx, dout};
            if (have_prev && low_run != 1) gap_bad++;
            wcnt = 0;
         end else if ({type_tx, dout} !== hold_val) begin
            stab_bad++;
         end
         if (wcnt == ack_dly) begin
            ack_tx = 1'b1;
            got.push_back({type_tx, dout});
            if (type_tx) words++;
            wcnt = 0;
         end else begin
            ack_tx = 1'b0;
            wcnt++;
         end
         low_run   = 0;
         have_prev = 1'b1;
      end else begin
         ack_tx = force_ack;
         low_run++;
      end
      prev_req = req_tx;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] hc(input int n);
      if (n < 10) return 8'(48 + n);
      return 8'(55 + n);
   endfunction

   task automatic push_crlf();
      exp_q.push_back({1'b0, 24'h0, 8'h0D});
      exp_q.push_back({1'b0, 24'h0, 8'h0A});
   endtask

   task automatic build(input int st, input int n);
      for (int i = 0; i < n; i++) begin
         int a;
         a = (st + i) % NREG;
         exp_q.push_back({1'b0, 24'h0, PFXC});
         exp_q.push_back({1'b0, 24'h0, hc((a >> 4) & 15)});
         exp_q.push_back({1'b0, 24'h0, hc(a & 15)});
         exp_q.push_back({1'b0, 24'h0, 8'h3D});
         exp_q.push_back({1'b1, rf[a]});
`ifdef DCP_LINE_CRLF_EN
         if (i < n - 1) push_crlf();
`endif
      end
      push_crlf();
   endtask

   task automatic compare(input string tag);
      int n;
      chk({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_item%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
   endtask

   task automatic wait_done(input string tag, input int budget);
      int c;
      c = 0;
      while (!finish && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk({tag, "_done"}, 64'(finish), 64'd1);
   endtask

   task automatic start_dump(input int st, input int cnt, input int dly);
      @(negedge clk);
      got.delete();
      exp_q.delete();
      have_prev  = 1'b0;
      gap_bad    = 0;
      stab_bad   = 0;
      words      = 0;
      ack_dly    = dly;
      start_addr = AW'(st);
      count      = (AW+1)'(cnt);
      sel_mode   = CMD;
   endtask

   task automatic run(input string tag, input int st, input int cnt, input int n, input int dly);
      start_dump(st, cnt, dly);
      build(st, n);
      wait_done(tag, 4000);
      repeat (3) @(negedge clk);
      chk({tag, "_finhold"}, 64'(finish), 64'd1);
      chk({tag, "_reqidle"}, 64'(req_tx), 64'd0);
      chk({tag, "_addr"}, 64'(addr), 64'((st + n) % NREG));
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk({tag, "_stray_ack_fin"}, 64'(finish), 64'd1);
      chk({tag, "_stray_ack_req"}, 64'(req_tx), 64'd0);
      chk({tag, "_gap"}, 64'(gap_bad), 64'd0);
      chk({tag, "_stable"}, 64'(stab_bad), 64'd0);
      compare(tag);
      sel_mode = 8'h00;
      @(negedge clk);
      chk({tag, "_desel_fin"}, 64'(finish), 64'd0);
   endtask

   initial begin
      int c;
      int nsz;
      for (int i = 0; i < NREG; i++) rf[i] = (32'h0101_0101 * i) ^ 32'hA5C3_0F00;
      rf[0] = 32'h1234_5678;
      rf[1] = 32'hDEAD_BEEF;

      repeat (2) @(negedge clk);
      chk("rst_req", 64'(req_tx), 64'd0);
      chk("rst_fin", 64'(finish), 64'd0);
      chk("rst_dout", 64'(dout), 64'd0);
      chk("rst_type", 64'(type_tx), 64'd0);
      chk("rst_addr", 64'(addr), 64'd0);
      rstn = 1'b1;

      run("basic", 0, 2, 2, 0);
      run("wrap", 31, 2, 2, 0);
      run("full", 0, 0, 32, 0);
      run("clamp", 3, 33, 32, 0);
      run("slow", 5, 2, 2, 7);

      // abort while the second data word is being requested
      start_dump(0, 3, 3);
      c = 0;
      while (!(req_tx && type_tx && words == 1) && c < 500) begin
         @(negedge clk);
         c++;
      end
      chk("abort_reached", 64'(req_tx && type_tx && words == 1), 64'd1);
      sel_mode = 8'h00;
      nsz = got.size();
      @(negedge clk);
      chk("abort_req", 64'(req_tx), 64'd0);
      chk("abort_dout", 64'(dout), 64'd0);
      repeat (10) @(negedge clk);
      chk("abort_nocrlf", 64'(got.size()), 64'(nsz));
      chk("abort_fin", 64'(finish), 64'd0);
      got.delete();
      exp_q.delete();
      build(0, 3);
      have_prev = 1'b0;
      gap_bad   = 0;
      stab_bad  = 0;
      sel_mode  = CMD;
      wait_done("reselect", 4000);
      compare("reselect");
      chk("reselect_gap", 64'(gap_bad), 64'd0);
      sel_mode = 8'h00;
      @(negedge clk);

      // asynchronous reset during the address digits
      start_dump(4, 2, 2);
      c = 0;
      while (!(got.size() == 1 && req_tx) && c < 500) begin
         @(negedge clk);
         c++;
      end
      chk("rstmid_reached", 64'(got.size() == 1 && req_tx), 64'd1);
      chk("rstmid_addr_pre", 64'(addr), 64'd4);
      rstn = 1'b0;
      #1;
      chk("rstmid_req", 64'(req_tx), 64'd0);
      chk("rstmid_fin", 64'(finish), 64'd0);
      chk("rstmid_dout", 64'(dout), 64'd0);
      chk("rstmid_type", 64'(type_tx), 64'd0);
      chk("rstmid_addr", 64'(addr), 64'd0);
      @(negedge clk);
      got.delete();
      exp_q.delete();
      build(4, 2);
      have_prev = 1'b0;
      gap_bad   = 0;
      stab_bad  = 0;
      rstn      = 1'b1;
      wait_done("rstmid_restart", 4000);
      compare("rstmid_restart");
      chk("rstmid_gap", 64'(gap_bad), 64'd0);
      chk("rstmid_stable", 64'(stab_bad), 64'd0);
      sel_mode = 8'h00;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
